// File: rtl/mm_pkg.sv
// Shared definitions for the single-core matrix-multiplier datapath.
// Holds the default operand/accumulator/counter widths and the 2-bit
// state encoding used by the MAC controller.
package mm_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 24;
  localparam int CNT_WIDTH_DEF  = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mac_unit_if.sv
// Bus between the operand/control side and the MAC unit.
//   start, len        : job request and dot-product length
//   a_in, b_in        : operand pair from the A/B operand registers
//   in_valid/in_ready : per-pair handshake
//   acc_out, done     : result and one-cycle completion pulse
//   busy, overflow    : job-in-progress flag and sticky wrap flag
// master = the side issuing jobs and operands, slave = the MAC unit.
interface mac_unit_if
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

  logic                  start;
  logic [CNT_WIDTH-1:0]  len;
  logic [DATA_WIDTH-1:0] a_in;
  logic [DATA_WIDTH-1:0] b_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic                  done;
  logic                  busy;
  logic                  overflow;

  modport master (
    output start, len, a_in, b_in, in_valid,
    input  in_ready, acc_out, done, busy, overflow
  );

  modport slave (
    input  start, len, a_in, b_in, in_valid,
    output in_ready, acc_out, done, busy, overflow
  );

endinterface

// File: rtl/mac_unit_datapath.sv
// mac_datapath: unsigned multiply-accumulate with a sticky wrap flag.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the accumulator and overflow flag (new job)
//   en       : add a*b into the accumulator this cycle
//   a, b     : unsigned operands
//   acc      : accumulator value (wraps modulo 2^ACC_WIDTH)
//   ovf      : set when any accumulation carried out of ACC_WIDTH bits
module mac_datapath
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  ovf
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH:0]      sum;
  logic [ACC_WIDTH-1:0]    acc_d, acc_q;
  logic                    ovf_d, ovf_q;

  always_comb begin
    prod = a * b;
    // One extra bit so the carry out of the accumulator is observable.
    sum  = {1'b0, acc_q} + (ACC_WIDTH+1)'(prod);

    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      acc_d = sum[ACC_WIDTH-1:0];
      if (sum[ACC_WIDTH]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mac_unit.sv
// mac_unit: dot-product accumulator for one output matrix element.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mac_unit_if.slave carrying start/len, the a_in/b_in pair
//              with in_valid/in_ready handshake, and acc_out, done,
//              busy, overflow back to write-back logic.
// Controller flow IDLE -> ACCUM -> DONE -> IDLE; a zero-length job goes
// straight from IDLE to DONE with a zero result.
module mac_unit
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input logic       clk,
  input logic       rst,
  mac_unit_if.slave bus
);

  logic [1:0]           state_d, state_q;
  logic [CNT_WIDTH-1:0] len_d, len_q;
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 in_ready;
  logic                 consume;
  logic                 dp_clear;
  logic                 dp_en;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;

  assign in_ready = (state_q == ST_ACCUM);
  assign consume  = bus.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    count_d  = count_q;
    dp_clear = 1'b0;
    dp_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dp_clear = 1'b1;
          count_d  = '0;
          if (bus.len != '0) begin
            len_d   = bus.len;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (consume) begin
          dp_en   = 1'b1;
          count_d = count_q + CNT_WIDTH'(1);
          if (count_q == len_q - CNT_WIDTH'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  mac_datapath #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .clear (dp_clear),
    .en    (dp_en),
    .a     (bus.a_in),
    .b     (bus.b_in),
    .acc   (acc),
    .ovf   (ovf)
  );

  assign bus.in_ready = in_ready;
  assign bus.acc_out  = acc;
  assign bus.overflow = ovf;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.busy     = (state_q == ST_ACCUM) || (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_unit.sv
// Directed testbench for mac_unit: reset, back-to-back sum, bubbles,
// zero length, overflow wrap, ignored start, reset mid-job.
module tb_mac_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  int   cons_cnt;

  mac_unit_if #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(10)) bus ();

  mac_unit #(.DATA_WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) cons_cnt <= cons_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    bus.start = 1'b1;
    bus.len   = 10'(l);
    step();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int a, input int b);
    bus.a_in     = 8'(a);
    bus.b_in     = 8'(b);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (bus.acc_out !== 24'd0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", bus.acc_out); end
    total++; if ({bus.in_ready, bus.done, bus.busy, bus.overflow} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.in_ready, bus.done, bus.busy, bus.overflow});
    end
  endtask

  task automatic test_basic();
    int t0, d0;
    t0 = cyc; d0 = done_cnt;
    do_start(3);
    total++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL basic_accum_state ready=%b busy=%b exp 1/1", bus.in_ready, bus.busy);
    end
    feed(1, 2);
    feed(3, 4);
    feed(5, 6);
    total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", bus.done); end
    total++; if (bus.acc_out !== 24'd44) begin bad++; $display("FAIL basic_acc got=%0d exp=44", bus.acc_out); end
    total++; if (cyc - t0 !== 4) begin bad++; $display("FAIL basic_latency got=%0d exp=4", cyc - t0); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b exp=0", bus.overflow); end
    step();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.acc_out !== 24'd44) begin
      bad++; $display("FAIL basic_after done=%b busy=%b acc=%0d exp 0/0/44", bus.done, bus.busy, bus.acc_out);
    end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_bubbles();
    int c0;
    do_start(3);
    c0 = cons_cnt;
    feed(1, 2);
    step(); step();
    total++; if (bus.acc_out !== 24'd2 || cons_cnt - c0 !== 1) begin
      bad++; $display("FAIL bubble_hold1 acc=%0d cons=%0d exp 2/1", bus.acc_out, cons_cnt - c0);
    end
    feed(3, 4);
    step(); step();
    total++; if (bus.acc_out !== 24'd14 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bubble_hold2 acc=%0d done=%b ready=%b exp 14/0/1", bus.acc_out, bus.done, bus.in_ready);
    end
    feed(5, 6);
    total++; if (bus.done !== 1'b1 || bus.acc_out !== 24'd44) begin
      bad++; $display("FAIL bubble_done done=%b acc=%0d exp 1/44", bus.done, bus.acc_out);
    end
    step();
  endtask

  task automatic test_zero_len();
    int c0;
    c0 = cons_cnt;
    bus.a_in = 8'd9; bus.b_in = 8'd9; bus.in_valid = 1'b1;
    do_start(0);
    total++; if (bus.done !== 1'b1 || bus.acc_out !== 24'd0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL zero_done done=%b acc=%0d ready=%b exp 1/0/0", bus.done, bus.acc_out, bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || cons_cnt != c0) begin
      bad++; $display("FAIL zero_after done=%b busy=%b cons=%0d exp 0/0/0", bus.done, bus.busy, cons_cnt - c0);
    end
  endtask

  task automatic test_overflow();
    do_start(300);
    for (int i = 0; i < 300; i++) feed(255, 255);
    total++; if (bus.done !== 1'b1 || bus.acc_out !== 24'd2730284) begin
      bad++; $display("FAIL ovf_acc done=%b acc=%0d exp 1/2730284", bus.done, bus.acc_out);
    end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
    step(); step();
    total++; if (bus.overflow !== 1'b1 || bus.acc_out !== 24'd2730284) begin
      bad++; $display("FAIL ovf_sticky ovf=%b acc=%0d exp 1/2730284", bus.overflow, bus.acc_out);
    end
    do_start(1);
    total++; if (bus.overflow !== 1'b0 || bus.acc_out !== 24'd0) begin
      bad++; $display("FAIL ovf_clear ovf=%b acc=%0d exp 0/0", bus.overflow, bus.acc_out);
    end
    feed(2, 3);
    total++; if (bus.done !== 1'b1 || bus.acc_out !== 24'd6 || bus.overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_next done=%b acc=%0d ovf=%b exp 1/6/0", bus.done, bus.acc_out, bus.overflow);
    end
    step();
  endtask

  task automatic test_ignored_start();
    do_start(2);
    bus.start = 1'b1; bus.len = 10'd5;
    feed(10, 10);
    bus.start = 1'b0;
    total++; if (bus.done !== 1'b0 || bus.in_ready !== 1'b1 || bus.acc_out !== 24'd100) begin
      bad++; $display("FAIL ign_mid done=%b ready=%b acc=%0d exp 0/1/100", bus.done, bus.in_ready, bus.acc_out);
    end
    feed(1, 1);
    total++; if (bus.done !== 1'b1 || bus.acc_out !== 24'd101) begin
      bad++; $display("FAIL ign_done done=%b acc=%0d exp 1/101", bus.done, bus.acc_out);
    end
    // start seen while in DONE must not launch a job
    bus.start = 1'b1; bus.len = 10'd3;
    step();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.acc_out !== 24'd101) begin
      bad++; $display("FAIL ign_in_done busy=%b ready=%b acc=%0d exp 0/0/101", bus.busy, bus.in_ready, bus.acc_out);
    end
  endtask

  task automatic test_reset_mid();
    do_start(3);
    feed(4, 4);
    rst = 1'b1;
    bus.a_in = 8'd9; bus.b_in = 8'd9; bus.in_valid = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (bus.acc_out !== 24'd0 || {bus.in_ready, bus.done, bus.busy, bus.overflow} !== 4'b0000) begin
      bad++; $display("FAIL rstmid_outputs acc=%0d flags=%b exp 0/0000", bus.acc_out,
                      {bus.in_ready, bus.done, bus.busy, bus.overflow});
    end
    step();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_idle busy=%b exp=0", bus.busy); end
    do_start(1);
    feed(7, 7);
    total++; if (bus.done !== 1'b1 || bus.acc_out !== 24'd49) begin
      bad++; $display("FAIL rstmid_next done=%b acc=%0d exp 1/49", bus.done, bus.acc_out);
    end
    step();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; done_cnt = 0; cons_cnt = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0;
    test_reset();
    test_basic();
    test_bubbles();
    test_zero_len();
    test_overflow();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Consumes operand pairs from two upstream `register` instances (A-row element, B-column element).
- Accumulates a dot product of programmable length for one output matrix element.
- Sits directly downstream of the operand registers in the single-core multiplier datapath.
- Presents the finished sum with a one-cycle done pulse to the result write-back logic.

Parameters:
- DATA_WIDTH, 8, width of each unsigned operand (matches the operand register width).
- ACC_WIDTH, 24, width of the accumulator and result.
- CNT_WIDTH, 10, width of the length and counter fields; maximum dot-product length is 2^CNT_WIDTH-1.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a new dot product; sampled only in IDLE.
- len  input  CNT_WIDTH  number of operand pairs; latched on an accepted start.
- a_in  input  DATA_WIDTH  operand A, driven from the A register's data_out.
- b_in  input  DATA_WIDTH  operand B, driven from the B register's data_out.
- in_valid  input  1  a_in/b_in hold a fresh pair.
- in_ready  output  1  block will accept a pair this cycle.
- acc_out  output  ACC_WIDTH  accumulated result.
- done  output  1  one-cycle pulse; result final.
- busy  output  1  high in ACCUM and DONE.
- overflow  output  1  sticky; accumulation wrapped during the current job.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - acc_out=0, count=0, in_ready=0, done=0, busy=0, overflow=0.
  - Reset wins over every other input, including mid-job; the partial sum is discarded.
- States: IDLE, ACCUM, DONE. Encoding is binary, 2 bits.
- IDLE:
  - in_ready=0, busy=0, acc_out holds the previous result.
  - start=1 with len>0: latch len, clear acc_out, count and overflow; go to ACCUM.
  - start=1 with len==0: clear acc_out and overflow; go to DONE. The result is 0.
- ACCUM:
  - in_ready=1, busy=1.
  - Handshake: a pair is consumed only on a cycle where in_valid && in_ready.
  - When in_valid=0, acc_out and count hold.
  - On consume:
    - acc_out <= acc_out + a_in*b_in, unsigned.
    - The 2*DATA_WIDTH product is zero-extended to ACC_WIDTH+1.
    - The sum is truncated to ACC_WIDTH (wrap-around).
    - If bit ACC_WIDTH of the sum is 1, overflow <= 1; it stays set until the next start.
    - count <= count+1.
  - Consume with count == len_latched-1: go to DONE.
  - start is ignored in ACCUM.
- DONE:
  - Exactly one cycle; done=1, busy=1, in_ready=0.
  - acc_out is final. Next state is IDLE.
  - start is ignored in DONE.
- Latency: done asserts on the cycle after the last pair is consumed. For back-to-back valid input, start-to-done is len+1 cycles.
- acc_out and overflow remain stable after DONE until the next accepted start or reset.
- The block never back-pressures mid-job except in DONE and IDLE. The upstream register write enable (we) is driven from in_valid && in_ready by the controller.

Decomposition:
- Shared package mm_pkg:
  - DATA_WIDTH and ACC_WIDTH defaults.
  - State encoding constants ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2.
- One sub-module, mac_datapath:
  - Contains the multiplier, the ACC_WIDTH+1 adder and the accumulator/overflow registers.
  - Inputs: clk, rst, clear, en, a, b. Outputs: acc, ovf.
  - The FSM and counter stay in mac_unit.

Test Plan:
- Basic sum: len=3, pairs (1,2),(3,4),(5,6) valid back-to-back.
  - acc_out=44 in the DONE cycle; done high exactly 1 cycle, 4 cycles after start; overflow=0.
- Bubbles: same pairs with in_valid low for 2 cycles between each pair.
  - acc_out=44; count does not advance on bubbles; done one cycle after the third consume.
- Zero length: start with len=0.
  - DONE the next cycle, acc_out=0, no pair consumed (in_ready never high).
- Overflow wrap: len=300, all pairs (255,255).
  - acc_out=2730284 (19507500 mod 2^24); overflow=1.
  - On the next start with len=1 and pair (2,3): overflow=0, acc_out=6.
- Ignored start: pulse start with len=5 during ACCUM of a len=2 job with pairs (10,10),(1,1).
  - acc_out=101; done after 2 consumes; len is not relatched.
- Reset mid-job: assert rst after 1 of 3 pairs consumed.
  - The next cycle has all outputs 0 and state IDLE.
  - A following len=1 job with pair (7,7) gives acc_out=49.
